// File: rtl/alu_sequencer_if.sv
// Instruction handshake and completion bus of alu_sequencer.
// The master offers instructions; the slave (the sequencer) reports done/result.
interface alu_sequencer_if;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic       done;
  logic [7:0] result;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready,
    input  done,
    input  result
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready,
    output done,
    output result
  );
endinterface

// File: rtl/alu_sequencer.sv
// Four-register sequencer driving an external combinational ALU: IDLE -> READ -> EXEC -> WB.
// Define ALU_SEQ_FLAGS_EN to enable carry/zero flags, carry chaining and CMP flag updates.
module alu_sequencer (
  input  logic                clk,
  input  logic                rst_n,
  alu_sequencer_if.slave      bus,
  input  logic                ld_en,
  input  logic [1:0]          ld_addr,
  input  logic [7:0]          ld_data,
  input  logic [1:0]          rd_addr,
  output logic [7:0]          rd_data,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [2:0]          alu_opcode,
  output logic                alu_carry_in,
  input  logic [7:0]          alu_out,
  output logic                carry_flag,
  output logic                zero_flag
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned REG_N  = 4;
  localparam int unsigned RIDX_W = 2;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SHR = 3'b001;
  localparam logic [OP_W-1:0] OP_SHL = 3'b010;
  localparam logic [OP_W-1:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   regs [REG_N];
  logic [DATA_W-1:0]   res_q;
  logic [OP_W-1:0]     op_q;
  logic [RIDX_W-1:0]   rd_q;
  logic [RIDX_W-1:0]   rs_q;

`ifdef ALU_SEQ_FLAGS_EN
  logic                use_carry_q;
  logic [DATA_W:0]     sum_c;

  // Local 9-bit sum gives the ADD carry independent of the external ALU.
  assign sum_c = (DATA_W+1)'(alu_a) + (DATA_W+1)'(alu_b) + (DATA_W+1)'(alu_carry_in);
`endif

  assign rd_data = regs[rd_addr];

  // Sequencer state, register file and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
      res_q           <= '0;
      op_q            <= '0;
      rd_q            <= '0;
      rs_q            <= '0;
      alu_a           <= '0;
      alu_b           <= '0;
      alu_opcode      <= '0;
      alu_carry_in    <= 1'b0;
      bus.instr_ready <= 1'b1;
      bus.done        <= 1'b0;
      bus.result      <= '0;
      carry_flag      <= 1'b0;
      zero_flag       <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      use_carry_q     <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (ld_en) regs[ld_addr] <= ld_data;
          if (bus.instr_valid) begin
            op_q            <= bus.instr[7:5];
            rd_q            <= bus.instr[4:3];
            rs_q            <= bus.instr[2:1];
`ifdef ALU_SEQ_FLAGS_EN
            use_carry_q     <= bus.instr[0];
`endif
            bus.instr_ready <= 1'b0;
            state           <= S_READ;
          end
        end
        S_READ: begin
          alu_a      <= regs[rd_q];
          alu_b      <= regs[rs_q];
          alu_opcode <= op_q;
`ifdef ALU_SEQ_FLAGS_EN
          alu_carry_in <= use_carry_q & carry_flag;
`else
          alu_carry_in <= 1'b0;
`endif
          state      <= S_EXEC;
        end
        S_EXEC: begin
          res_q <= alu_out;
          state <= S_WB;
        end
        S_WB: begin
          if (alu_opcode != OP_CMP) begin
            regs[rd_q] <= res_q;
            bus.result <= res_q;
`ifdef ALU_SEQ_FLAGS_EN
            zero_flag  <= (res_q == '0);
            if (alu_opcode == OP_ADD)      carry_flag <= sum_c[DATA_W];
            else if (alu_opcode == OP_SHR) carry_flag <= alu_a[0];
            else if (alu_opcode == OP_SHL) carry_flag <= alu_a[DATA_W-1];
`endif
          end
`ifdef ALU_SEQ_FLAGS_EN
          else begin
            // CMP only updates flags; the register file and result are untouched.
            zero_flag  <= (alu_a == alu_b);
            carry_flag <= (alu_a < alu_b);
          end
`endif
          bus.done        <= 1'b1;
          bus.instr_ready <= 1'b1;
          state           <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
